reg_watch: RTL and testbench

Synthesizable register-file monitor for the RISC-V SoC. It snoops the core's register write port and keeps shadow copies of a parametrised window of architectural registers. Changes to watched registers are queued as events behind a valid/ready handshake. A completion FSM decides pass, fail or timeout from the done/pass register convention. It sits beside `core_inst`, is driven from the register write-back signals, and replaces hierarchical-reference polling in benches and on-board status LEDs.

---
 rtl/reg_watch_pkg.sv | 21 ++
 rtl/reg_watch_if.sv | 27 ++
 rtl/reg_watch_fifo.sv | 62 ++++++
 rtl/reg_watch.sv | 151 +++++++++++++++
 tb/tb_reg_watch.sv | 230 +++++++++++++++++++++++
 5 files changed

// File: rtl/reg_watch_pkg.sv
// rtl/reg_watch_pkg.sv - shared encodings and defaults for the register-file monitor
// Contents:
//   state_e          : FSM state encoding seen on state_o (IDLE..TIMEOUT)
//   DEFAULT_DONE_REG : register whose nonzero write ends a test
//   DEFAULT_PASS_REG : register holding the result code
//   PASS_CODE        : result code value that means pass
package reg_watch_pkg;

   typedef enum logic [2:0] {
      ST_IDLE    = 3'd0,
      ST_RUN     = 3'd1,
      ST_PASS    = 3'd2,
      ST_FAIL    = 3'd3,
      ST_TIMEOUT = 3'd4
   } state_e;

   localparam int DEFAULT_DONE_REG = 26;
   localparam int DEFAULT_PASS_REG = 27;
   localparam int PASS_CODE        = 1;

endpackage

// File: rtl/reg_watch_if.sv
// rtl/reg_watch_if.sv - register write-port snoop and event stream bundle
// Signals:
//   wr_en, wr_addr, wr_data         : register-file write port (core -> monitor)
//   evt_valid, evt_idx, evt_data    : head event (monitor -> consumer)
//   evt_ready                       : consumer accepts head event
// Modports: master = core/consumer side, slave = monitor side.
interface reg_watch_if #(
   parameter int XLEN = 32
);
   logic            wr_en;
   logic [4:0]      wr_addr;
   logic [XLEN-1:0] wr_data;
   logic            evt_valid;
   logic            evt_ready;
   logic [4:0]      evt_idx;
   logic [XLEN-1:0] evt_data;

   modport master (
      output wr_en, wr_addr, wr_data, evt_ready,
      input  evt_valid, evt_idx, evt_data
   );

   modport slave (
      input  wr_en, wr_addr, wr_data, evt_ready,
      output evt_valid, evt_idx, evt_data
   );
endinterface

// File: rtl/reg_watch_fifo.sv
// rtl/reg_watch_fifo.sv - synchronous event FIFO, registered storage, no fall-through
// Ports:
//   clk, rst_n : clock, asynchronous active-low reset
//   clr        : synchronous flush of all entries
//   push, din  : write request and data (dropped when full unless popping)
//   pop        : read request (ignored when empty)
//   dout       : head entry, zero when empty
//   full,empty : occupancy flags
module reg_watch_fifo #(
   parameter int WIDTH = 37,
   parameter int DEPTH = 4
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             clr,
   input  logic             push,
   input  logic             pop,
   input  logic [WIDTH-1:0] din,
   output logic [WIDTH-1:0] dout,
   output logic             full,
   output logic             empty
);
   localparam int AW = $clog2(DEPTH);

   logic [WIDTH-1:0] mem [DEPTH];
   logic [AW-1:0]    rd_ptr;
   logic [AW-1:0]    wr_ptr;
   logic [AW:0]      count;
   logic             do_pop;
   logic             do_push;

   assign full    = (count == (AW+1)'(DEPTH));
   assign empty   = (count == '0);
   assign do_pop  = pop && !empty;
   // A pop in the same cycle frees the slot, so a push into a full FIFO still lands.
   assign do_push = push && (!full || do_pop);
   assign dout    = empty ? '0 : mem[rd_ptr];

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         rd_ptr <= '0;
         wr_ptr <= '0;
         count  <= '0;
      end else if (clr) begin
         rd_ptr <= '0;
         wr_ptr <= '0;
         count  <= '0;
      end else begin
         if (do_push) wr_ptr <= wr_ptr + 1'b1;
         if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
         case ({do_push, do_pop})
            2'b10:   count <= count + 1'b1;
            2'b01:   count <= count - 1'b1;
            default: count <= count;
         endcase
      end
   end

   always_ff @(posedge clk) begin
      if (do_push && !clr) mem[wr_ptr] <= din;
   end
endmodule

// File: rtl/reg_watch.sv
// rtl/reg_watch.sv - register-file monitor: shadow window, change events, completion FSM
// Ports:
//   clk, rst_n   : clock, asynchronous active-low reset
//   start        : one-cycle pulse, arms the monitor from IDLE or a terminal state
//   bus          : write-port snoop in, event stream out (reg_watch_if.slave)
//   watch_val    : shadow values, slice i = register WATCH_BASE+i
//   evt_overflow : sticky, an event was dropped
//   state_o      : FSM state (reg_watch_pkg::state_e)
//   cycle_cnt    : saturating RUN cycle count
// Build option: REG_WATCH_EVT_FIFO_EN enables the event FIFO; otherwise events are tied off.
module reg_watch
   import reg_watch_pkg::*;
#(
   parameter int XLEN           = 32,
   parameter int NUM_WATCH      = 3,
   parameter int WATCH_BASE     = 27,
   parameter int DONE_REG       = DEFAULT_DONE_REG,
   parameter int PASS_REG       = DEFAULT_PASS_REG,
   parameter int TIMEOUT_CYCLES = 100000,
   parameter int FIFO_DEPTH     = 4
) (
   input  logic                      clk,
   input  logic                      rst_n,
   input  logic                      start,
   reg_watch_if.slave                bus,
   output logic [NUM_WATCH*XLEN-1:0] watch_val,
   output logic                      evt_overflow,
   output logic [2:0]                state_o,
   output logic [31:0]               cycle_cnt
);
   state_e          state;
   state_e          state_nx;
   logic [XLEN-1:0] shadow [NUM_WATCH];
   logic [XLEN-1:0] pass_shadow;
   logic            qual;
   logic            arm;
   logic            hit;
   logic            changed;
   logic            push;
   logic            done_hit;
   logic            timeout_hit;

   assign qual        = bus.wr_en && (bus.wr_addr != 5'd0);
   assign arm         = start && (state != ST_RUN);
   assign done_hit    = (state == ST_RUN) && qual && (bus.wr_addr == 5'(DONE_REG)) && (bus.wr_data != '0);
   assign timeout_hit = (cycle_cnt == 32'(TIMEOUT_CYCLES - 1));
   assign push        = (state == ST_RUN) && qual && hit && changed;
   assign state_o     = state;

   always_comb begin
      hit     = 1'b0;
      changed = 1'b0;
      for (int i = 0; i < NUM_WATCH; i++) begin
         if (bus.wr_addr == 5'(WATCH_BASE + i)) begin
            hit     = 1'b1;
            changed = (shadow[i] != bus.wr_data);
         end
      end
   end

   // Shadows track writes in every state; start does not clear them.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int i = 0; i < NUM_WATCH; i++) shadow[i] <= '0;
         pass_shadow <= '0;
      end else begin
         for (int i = 0; i < NUM_WATCH; i++) begin
            if (qual && (bus.wr_addr == 5'(WATCH_BASE + i))) shadow[i] <= bus.wr_data;
         end
         // Kept separately so PASS_REG may lie outside the watch window.
         if (qual && (bus.wr_addr == 5'(PASS_REG))) pass_shadow <= bus.wr_data;
      end
   end

   for (genvar g = 0; g < NUM_WATCH; g++) begin : g_watch
      assign watch_val[g*XLEN +: XLEN] = shadow[g];
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) state <= ST_IDLE;
      else        state <= state_nx;
   end

   always_comb begin
      state_nx = state;
      case (state)
         ST_RUN: begin
            // DONE is checked first so it wins over a coincident timeout.
            if (done_hit)
               state_nx = (pass_shadow == XLEN'(PASS_CODE)) ? ST_PASS : ST_FAIL;
            else if (timeout_hit)
               state_nx = ST_TIMEOUT;
         end
         default: begin
            if (start) state_nx = ST_RUN;
         end
      endcase
   end

   // Counts RUN cycles that stay in RUN, so the count freezes at TIMEOUT_CYCLES-1 on timeout.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n)
         cycle_cnt <= '0;
      else if (arm)
         cycle_cnt <= '0;
      else if ((state == ST_RUN) && (state_nx == ST_RUN) && (cycle_cnt != '1))
         cycle_cnt <= cycle_cnt + 1'b1;
   end

`ifdef REG_WATCH_EVT_FIFO_EN
   logic            fifo_full;
   logic            fifo_empty;
   logic [4+XLEN:0] fifo_dout;
   logic            ovf_q;

   reg_watch_fifo #(
      .WIDTH (5 + XLEN),
      .DEPTH (FIFO_DEPTH)
   ) u_fifo (
      .clk   (clk),
      .rst_n (rst_n),
      .clr   (arm),
      .push  (push),
      .pop   (bus.evt_ready),
      .din   ({bus.wr_addr, bus.wr_data}),
      .dout  (fifo_dout),
      .full  (fifo_full),
      .empty (fifo_empty)
   );

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n)
         ovf_q <= 1'b0;
      else if (arm)
         ovf_q <= 1'b0;
      else if (push && fifo_full && !bus.evt_ready)
         ovf_q <= 1'b1;
   end

   assign bus.evt_valid              = !fifo_empty;
   assign {bus.evt_idx, bus.evt_data} = fifo_dout;
   assign evt_overflow               = ovf_q;
`else
   logic unused_evt;
   assign unused_evt   = bus.evt_ready ^ push;
   assign bus.evt_valid = 1'b0;
   assign bus.evt_idx   = '0;
   assign bus.evt_data  = '0;
   assign evt_overflow  = 1'b0;
`endif
endmodule

// File: tb/tb_reg_watch.sv
// tb/tb_reg_watch.sv - directed vector bench for reg_watch
module tb_reg_watch;
   import reg_watch_pkg::*;

   localparam int XLEN = 32;
   localparam int NW   = 3;
   localparam int TO   = 16;
`ifdef REG_WATCH_EVT_FIFO_EN
   localparam logic FIFO_ON = 1'b1;
`else
   localparam logic FIFO_ON = 1'b0;
`endif

   logic                clk = 1'b0;
   logic                rst_n = 1'b0;
   logic                start = 1'b0;
   logic [NW*XLEN-1:0]  watch_val;
   logic                evt_overflow;
   logic [2:0]          state_o;
   logic [31:0]         cycle_cnt;
   int                  checks = 0;
   int                  failures = 0;

   always #5 clk = ~clk;

   reg_watch_if #(.XLEN(XLEN)) bus ();

   reg_watch #(
      .XLEN(XLEN), .NUM_WATCH(NW), .WATCH_BASE(27), .DONE_REG(26),
      .PASS_REG(27), .TIMEOUT_CYCLES(TO), .FIFO_DEPTH(4)
   ) dut (
      .clk(clk), .rst_n(rst_n), .start(start), .bus(bus),
      .watch_val(watch_val), .evt_overflow(evt_overflow),
      .state_o(state_o), .cycle_cnt(cycle_cnt)
   );

   typedef struct {
      logic        st;
      logic        we;
      logic [4:0]  ad;
      logic [31:0] dt;
      logic        rdy;
      logic [2:0]  e_state;
      logic [31:0] e_w0;
      logic [31:0] e_w1;
      logic [31:0] e_w2;
      logic        e_valid;
      logic [4:0]  e_idx;
      logic [31:0] e_data;
      logic        e_ovf;
      logic        chk_cnt;
      logic [31:0] e_cnt;
   } vec_t;

   vec_t vt [20];

   function automatic vec_t mk(input logic st, input logic we, input logic [4:0] ad,
                               input logic [31:0] dt, input logic rdy, input logic [2:0] es,
                               input logic [31:0] w0, input logic [31:0] w1, input logic [31:0] w2,
                               input logic ev, input logic [4:0] ei, input logic [31:0] ed,
                               input logic eo, input logic cc, input logic [31:0] ecnt);
      vec_t v;
      v.st = st; v.we = we; v.ad = ad; v.dt = dt; v.rdy = rdy;
      v.e_state = es; v.e_w0 = w0; v.e_w1 = w1; v.e_w2 = w2;
      v.e_valid = ev; v.e_idx = ei; v.e_data = ed; v.e_ovf = eo;
      v.chk_cnt = cc; v.e_cnt = ecnt;
      return v;
   endfunction

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   task automatic check_evt(input string tag, input logic v, input logic [4:0] idx,
                            input logic [31:0] d, input logic ovf);
      logic on;
      on = v & FIFO_ON;
      check({tag, ".evt_valid"}, 64'(bus.evt_valid), 64'(on));
      check({tag, ".evt_idx"}, 64'(bus.evt_idx), on ? 64'(idx) : 64'd0);
      check({tag, ".evt_data"}, 64'(bus.evt_data), on ? 64'(d) : 64'd0);
      check({tag, ".evt_overflow"}, 64'(evt_overflow), 64'(ovf & FIFO_ON));
   endtask

   task automatic check_watch(input string tag, input logic [31:0] w0,
                              input logic [31:0] w1, input logic [31:0] w2);
      check({tag, ".w0"}, 64'(watch_val[31:0]), 64'(w0));
      check({tag, ".w1"}, 64'(watch_val[63:32]), 64'(w1));
      check({tag, ".w2"}, 64'(watch_val[95:64]), 64'(w2));
   endtask

   // Inputs change on the falling edge; results are sampled on the next falling edge.
   task automatic cyc(input logic st, input logic we, input logic [4:0] ad,
                      input logic [31:0] dt, input logic rdy);
      start        = st;
      bus.wr_en    = we;
      bus.wr_addr  = ad;
      bus.wr_data  = dt;
      bus.evt_ready = rdy;
      @(negedge clk);
      start     = 1'b0;
      bus.wr_en = 1'b0;
   endtask

   initial begin
      #100000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      int n;
      int k;
      logic [31:0] drain_exp [3];

      bus.wr_en = 1'b0; bus.wr_addr = '0; bus.wr_data = '0; bus.evt_ready = 1'b0;

      //   st we  ad  dt rdy | state w0 w1 w2 | vld idx data ovf | chk cnt
      vt[0]  = mk(1, 0,  0, 0, 0,   1, 0, 0, 0,   0,  0, 0, 0,   1, 0);
      vt[1]  = mk(0, 1, 27, 1, 0,   1, 1, 0, 0,   1, 27, 1, 0,   1, 1);
      vt[2]  = mk(0, 1, 26, 1, 0,   2, 1, 0, 0,   1, 27, 1, 0,   0, 0);
      vt[3]  = mk(0, 0,  0, 0, 1,   2, 1, 0, 0,   0,  0, 0, 0,   0, 0);
      vt[4]  = mk(1, 0,  0, 0, 0,   1, 1, 0, 0,   0,  0, 0, 0,   1, 0);
      vt[5]  = mk(0, 1, 27, 5, 0,   1, 5, 0, 0,   1, 27, 5, 0,   1, 1);
      vt[6]  = mk(0, 1, 26, 1, 0,   3, 5, 0, 0,   1, 27, 5, 0,   0, 0);
      vt[7]  = mk(1, 0,  0, 0, 0,   1, 5, 0, 0,   0,  0, 0, 0,   1, 0);
      vt[8]  = mk(0, 1, 28, 1, 0,   1, 5, 1, 0,   1, 28, 1, 0,   1, 1);
      vt[9]  = mk(0, 1, 28, 2, 0,   1, 5, 2, 0,   1, 28, 1, 0,   1, 2);
      vt[10] = mk(0, 1, 28, 3, 0,   1, 5, 3, 0,   1, 28, 1, 0,   1, 3);
      vt[11] = mk(0, 1, 28, 4, 0,   1, 5, 4, 0,   1, 28, 1, 0,   1, 4);
      vt[12] = mk(0, 1, 28, 5, 0,   1, 5, 5, 0,   1, 28, 1, 1,   1, 5);
      vt[13] = mk(0, 1, 28, 6, 0,   1, 5, 6, 0,   1, 28, 1, 1,   1, 6);
      vt[14] = mk(0, 0,  0, 0, 1,   1, 5, 6, 0,   1, 28, 2, 1,   1, 7);
      vt[15] = mk(0, 0,  0, 0, 1,   1, 5, 6, 0,   1, 28, 3, 1,   1, 8);
      vt[16] = mk(0, 0,  0, 0, 1,   1, 5, 6, 0,   1, 28, 4, 1,   1, 9);
      vt[17] = mk(0, 0,  0, 0, 1,   1, 5, 6, 0,   0,  0, 0, 1,   1, 10);
      vt[18] = mk(0, 1, 26, 1, 1,   3, 5, 6, 0,   0,  0, 0, 1,   0, 0);
      vt[19] = mk(1, 0,  0, 0, 1,   1, 5, 6, 0,   0,  0, 0, 0,   1, 0);

      repeat (3) @(negedge clk);
      check("reset.state", 64'(state_o), 64'(ST_IDLE));
      check("reset.cnt", 64'(cycle_cnt), 64'd0);
      check_watch("reset", 0, 0, 0);
      check_evt("reset", 0, 0, 0, 0);
      rst_n = 1'b1;
      @(negedge clk);

      for (int i = 0; i < 20; i++) begin
         string tag;
         tag = $sformatf("v%0d", i);
         cyc(vt[i].st, vt[i].we, vt[i].ad, vt[i].dt, vt[i].rdy);
         check({tag, ".state"}, 64'(state_o), 64'(vt[i].e_state));
         check_watch(tag, vt[i].e_w0, vt[i].e_w1, vt[i].e_w2);
         check_evt(tag, vt[i].e_valid, vt[i].e_idx, vt[i].e_data, vt[i].e_ovf);
         if (vt[i].chk_cnt) check({tag, ".cnt"}, 64'(cycle_cnt), 64'(vt[i].e_cnt));
      end

      // Timeout: start inside RUN is ignored, TIMEOUT lands after 16 RUN cycles.
      for (n = 1; n <= 40; n++) begin
         cyc(n == 1, 0, 0, 0, 1);
         if (n == 1) begin
            check("run_start_ignored.state", 64'(state_o), 64'(ST_RUN));
            check("run_start_ignored.cnt", 64'(cycle_cnt), 64'd1);
         end
         if (state_o != 3'(ST_RUN)) break;
      end
      check("timeout.run_cycles", 64'(n), 64'd16);
      check("timeout.state", 64'(state_o), 64'(ST_TIMEOUT));
      check("timeout.cnt", 64'(cycle_cnt), 64'd15);
      repeat (3) cyc(0, 0, 0, 0, 1);
      check("timeout_hold.state", 64'(state_o), 64'(ST_TIMEOUT));
      check("timeout_hold.cnt", 64'(cycle_cnt), 64'd15);

      // DONE write in the timeout cycle wins.
      cyc(1, 0, 0, 0, 1);
      check("restart.cnt", 64'(cycle_cnt), 64'd0);
      cyc(0, 1, 27, 1, 1);
      for (k = 0; k < 40 && cycle_cnt != 32'd15; k++) cyc(0, 0, 0, 0, 1);
      check("last_cycle.cnt", 64'(cycle_cnt), 64'd15);
      check("last_cycle.state", 64'(state_o), 64'(ST_RUN));
      cyc(0, 1, 26, 1, 1);
      check("done_beats_timeout.state", 64'(state_o), 64'(ST_PASS));

      // Full FIFO with pop and push in the same cycle.
      cyc(1, 0, 0, 0, 0);
      for (int j = 0; j < 4; j++) cyc(0, 1, 28, 32'(10 + j), 0);
      check_evt("full", 1, 28, 10, 0);
      cyc(0, 1, 28, 14, 1);
      check_evt("full_push_pop", 1, 28, 11, 0);
      drain_exp[0] = 12; drain_exp[1] = 13; drain_exp[2] = 14;
      for (int j = 0; j < 3; j++) begin
         cyc(0, 0, 0, 0, 1);
         check_evt($sformatf("drain%0d", j), 1, 28, drain_exp[j], 0);
      end
      cyc(0, 0, 0, 0, 1);
      check_evt("drained", 0, 0, 0, 0);

      // Asynchronous reset mid-RUN with a pending event.
      cyc(0, 1, 29, 8, 0);
      check_evt("pre_reset", 1, 29, 8, 0);
      #2 rst_n = 1'b0;
      #1;
      check("async_reset.state", 64'(state_o), 64'(ST_IDLE));
      check("async_reset.cnt", 64'(cycle_cnt), 64'd0);
      check_watch("async_reset", 0, 0, 0);
      check_evt("async_reset", 0, 0, 0, 0);
      @(negedge clk);
      rst_n = 1'b1;

      // Shadows update in IDLE without events; equal writes and x0 are ignored.
      cyc(0, 1, 29, 3, 0);
      check("idle_write.state", 64'(state_o), 64'(ST_IDLE));
      check_watch("idle_write", 0, 0, 3);
      check_evt("idle_write", 0, 0, 0, 0);
      cyc(1, 0, 0, 0, 0);
      cyc(0, 1, 28, 7, 0);
      cyc(0, 1, 28, 7, 0);
      cyc(0, 1, 0, 9, 0);
      check_watch("x0_write", 0, 7, 3);
      check_evt("dup_write", 1, 28, 7, 0);
      cyc(0, 0, 0, 0, 1);
      check_evt("single_event", 0, 0, 0, 0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule
